// File: rtl/banco_registradores_ctx.sv
// Parametrised register file with write bypass, optional hard-wired r0 and a
// context engine that streams the whole bank out (save) or in (restore).
module banco_registradores_ctx #(
    parameter int TAM     = 16,
    parameter int AW      = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] reg_in,
    input  logic [AW-1:0]  selecaoin,
    input  logic           escreve,
    input  logic [AW-1:0]  selecaooutA,
    output logic [TAM-1:0] OUTA,
    input  logic [AW-1:0]  selecaooutB,
    output logic [TAM-1:0] OUTB,
    input  logic           salva,
    input  logic           restaura,
    output logic           ocupado,
    output logic [TAM-1:0] dump_dado,
    output logic           dump_valido,
    input  logic           dump_pronto,
    input  logic [TAM-1:0] carga_dado,
    input  logic           carga_valido,
    output logic           carga_pronto
);
    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {OCIOSO, SALVANDO, RESTAURANDO} estado_t;

    estado_t         estado_reg, estado_next;
    logic [AW-1:0]   ptr_reg, ptr_next;
    logic [TAM-1:0]  regs [NREG];
    logic            ocioso;
    logic            carga_hs;
    logic            ultimo;

    assign ocioso   = (estado_reg == OCIOSO);
    assign carga_hs = (estado_reg == RESTAURANDO) && carga_valido;
    assign ultimo   = (ptr_reg == AW'(NREG - 1));

    // Each register has a single write port shared by normal writes (idle only)
    // and restore words (addressed by ptr).
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (ZERO_R0 != 0 && gi == 0) begin : g_fixo
            assign regs[gi] = '0;
        end else begin : g_flop
            logic [TAM-1:0] valor_reg;
            logic           wr_en;

            assign wr_en = (ocioso && escreve && selecaoin == AW'(gi)) ||
                           (carga_hs && ptr_reg == AW'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valor_reg <= '0;
                end else if (wr_en) begin
                    valor_reg <= ocioso ? reg_in : carga_dado;
                end
            end

            assign regs[gi] = valor_reg;
        end
    end

    // Zero-forced r0 beats bypass; bypass only exists while the engine is idle.
    function automatic logic [TAM-1:0] le_porta(input logic [AW-1:0] addr);
        if (ZERO_R0 != 0 && addr == '0)
            return '0;
        else if (ocioso && escreve && selecaoin == addr)
            return reg_in;
        else
            return regs[addr];
    endfunction

    assign OUTA = le_porta(selecaooutA);
    assign OUTB = le_porta(selecaooutB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_reg <= OCIOSO;
            ptr_reg    <= '0;
        end else begin
            estado_reg <= estado_next;
            ptr_reg    <= ptr_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        ptr_next    = ptr_reg;
        case (estado_reg)
            OCIOSO: begin
                if (salva) begin
                    estado_next = SALVANDO;
                    ptr_next    = '0;
                end else if (restaura) begin
                    estado_next = RESTAURANDO;
                    ptr_next    = '0;
                end
            end
            SALVANDO: begin
                if (dump_pronto) begin
                    if (ultimo) begin
                        estado_next = OCIOSO;
                        ptr_next    = '0;
                    end else begin
                        ptr_next = ptr_reg + AW'(1);
                    end
                end
            end
            RESTAURANDO: begin
                if (carga_valido) begin
                    if (ultimo) begin
                        estado_next = OCIOSO;
                        ptr_next    = '0;
                    end else begin
                        ptr_next = ptr_reg + AW'(1);
                    end
                end
            end
            default: begin
                estado_next = OCIOSO;
                ptr_next    = '0;
            end
        endcase
    end

    assign ocupado      = !ocioso;
    assign dump_valido  = (estado_reg == SALVANDO);
    assign carga_pronto = (estado_reg == RESTAURANDO);
    assign dump_dado    = dump_valido ? regs[ptr_reg] : '0;

endmodule

// File: tb/tb_banco_registradores_ctx.sv
// Bench for banco_registradores_ctx: two instances (plain and zero-r0) share the
// same stimulus and are compared every cycle against a transaction-level model.
module tb_banco_registradores_ctx;
    localparam int NREG = 16;

    logic        clk, rst;
    logic [15:0] reg_in, carga_dado;
    logic [3:0]  selecaoin, selecaooutA, selecaooutB;
    logic        escreve, salva, restaura, dump_pronto, carga_valido;

    logic [15:0] outa0, outb0, ddado0, outa1, outb1, ddado1;
    logic        ocup0, dval0, cpronto0, ocup1, dval1, cpronto1;

    banco_registradores_ctx #(.TAM(16), .AW(4), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst), .reg_in(reg_in), .selecaoin(selecaoin), .escreve(escreve),
        .selecaooutA(selecaooutA), .OUTA(outa0), .selecaooutB(selecaooutB), .OUTB(outb0),
        .salva(salva), .restaura(restaura), .ocupado(ocup0),
        .dump_dado(ddado0), .dump_valido(dval0), .dump_pronto(dump_pronto),
        .carga_dado(carga_dado), .carga_valido(carga_valido), .carga_pronto(cpronto0)
    );

    banco_registradores_ctx #(.TAM(16), .AW(4), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .reg_in(reg_in), .selecaoin(selecaoin), .escreve(escreve),
        .selecaooutA(selecaooutA), .OUTA(outa1), .selecaooutB(selecaooutB), .OUTB(outb1),
        .salva(salva), .restaura(restaura), .ocupado(ocup1),
        .dump_dado(ddado1), .dump_valido(dval1), .dump_pronto(dump_pronto),
        .carga_dado(carga_dado), .carga_valido(carga_valido), .carga_pronto(cpronto1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_ok = 0;
    int n_total = 0;

    // Model: register contents per instance, plus "what the engine is doing"
    // (0 idle, 1 saving, 2 restoring) and how many words it has moved so far.
    logic [15:0] m_regs [2][NREG];
    int          modo;
    int          feitos;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, esp, $time);
    endtask

    task automatic zera_modelo();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREG; i++) m_regs[k][i] = 16'h0;
        modo   = 0;
        feitos = 0;
    endtask

    function automatic logic [15:0] esp_le(input int k, input logic [3:0] a);
        if (k == 1 && a == 4'd0) return 16'h0;
        if (modo == 0 && escreve && selecaoin == a) return reg_in;
        return m_regs[k][a];
    endfunction

    task automatic atualiza_modelo();
        case (modo)
            0: begin
                if (escreve)
                    for (int k = 0; k < 2; k++)
                        if (!(k == 1 && selecaoin == 4'd0)) m_regs[k][selecaoin] = reg_in;
                if (salva) begin modo = 1; feitos = 0; end
                else if (restaura) begin modo = 2; feitos = 0; end
            end
            1: if (dump_pronto) begin
                feitos++;
                if (feitos == NREG) modo = 0;
            end
            default: if (carga_valido) begin
                for (int k = 0; k < 2; k++)
                    if (!(k == 1 && feitos == 0)) m_regs[k][feitos] = carga_dado;
                feitos++;
                if (feitos == NREG) modo = 0;
            end
        endcase
    endtask

    // Inputs are already applied; check this cycle's outputs, advance the model
    // over the coming edge, and return just after the next falling edge.
    task automatic ciclo();
        if (rst) zera_modelo();
        #1;
        for (int k = 0; k < 2; k++) begin
            verifica($sformatf("OUTA%0d", k), k ? outa1 : outa0, esp_le(k, selecaooutA));
            verifica($sformatf("OUTB%0d", k), k ? outb1 : outb0, esp_le(k, selecaooutB));
            verifica($sformatf("ocupado%0d", k), k ? ocup1 : ocup0, modo != 0);
            verifica($sformatf("dump_valido%0d", k), k ? dval1 : dval0, modo == 1);
            verifica($sformatf("carga_pronto%0d", k), k ? cpronto1 : cpronto0, modo == 2);
            verifica($sformatf("dump_dado%0d", k), k ? ddado1 : ddado0,
                     (modo == 1) ? m_regs[k][feitos] : 16'h0);
        end
        if (!rst) atualiza_modelo();
        @(negedge clk);
        #1;
    endtask

    int n, palavras, kk;
    bit bolha;

    initial begin
        rst = 1'b1; reg_in = '0; carga_dado = '0; selecaoin = '0; selecaooutA = '0;
        selecaooutB = '0; escreve = 0; salva = 0; restaura = 0; dump_pronto = 0; carga_valido = 0;
        zera_modelo();
        @(negedge clk); #1;
        ciclo();
        verifica("reset_ocupado", ocup0, 0);
        rst = 1'b0;
        ciclo();

        // Write with same-cycle bypass
        escreve = 1; selecaoin = 4'd3; reg_in = 16'hA5A5; selecaooutA = 4'd3; selecaooutB = 4'd4;
        #1 verifica("bypass_r3", outa0, 16'hA5A5);
        ciclo();
        escreve = 0;
        #1 verifica("r3_apos", outa0, 16'hA5A5);
        verifica("r4_zero", outb0, 16'h0);
        ciclo();

        // Zero-forced r0
        escreve = 1; selecaoin = 4'd0; reg_in = 16'hFFFF; selecaooutA = 4'd0;
        #1 verifica("r0z_bypass", outa1, 16'h0);
        verifica("r0_bypass", outa0, 16'hFFFF);
        ciclo();
        escreve = 0;
        #1 verifica("r0z_apos", outa1, 16'h0);
        ciclo();

        // Preload regs[i] = 0x100 + i
        for (int i = 0; i < NREG; i++) begin
            escreve = 1; selecaoin = 4'(i); reg_in = 16'(16'h100 + i);
            ciclo();
        end
        escreve = 0;

        // Save with alternating backpressure; ignored write and restore meanwhile
        salva = 1; ciclo(); salva = 0;
        n = 0; palavras = 0;
        while (ocup0 && n < 100) begin
            dump_pronto = n[0];
            restaura = (n == 5);
            escreve = (n == 4); selecaoin = 4'd7; reg_in = 16'hBEEF;
            if (dump_pronto) begin
                verifica("dump_ordem", ddado0, 32'h100 + palavras);
                palavras++;
            end
            ciclo();
            n++;
        end
        restaura = 0; escreve = 0; dump_pronto = 0;
        verifica("save_ciclos", n, 2 * NREG);
        verifica("save_palavras", palavras, NREG);
        ciclo();
        verifica("restaura_ignorado", ocup0, 0);

        // Restore with one bubble and a blocked write to r5
        restaura = 1; ciclo(); restaura = 0;
        n = 0; kk = 0; bolha = 0; selecaooutA = 4'd5;
        while (ocup0 && n < 100) begin
            carga_valido = !(kk == 6 && !bolha);
            if (!carga_valido) bolha = 1;
            carga_dado = 16'(16'hB000 + kk);
            escreve = (n == 3); selecaoin = 4'd5; reg_in = 16'hDEAD;
            ciclo();
            if (carga_valido) kk++;
            n++;
        end
        carga_valido = 0; escreve = 0; selecaooutB = 4'd0;
        verifica("restore_ciclos", n, NREG + 1);
        #1 verifica("r5_final", outa0, 16'hB005);
        verifica("r0_restore", outb0, 16'hB000);
        verifica("r0z_restore", outb1, 16'h0);
        ciclo();

        // salva beats restaura; then reset in the middle of the save
        salva = 1; restaura = 1; ciclo(); salva = 0; restaura = 0;
        verifica("prioridade_salva", dval0, 1);
        verifica("prioridade_carga", cpronto0, 0);
        dump_pronto = 1;
        repeat (7) ciclo();
        dump_pronto = 0;
        verifica("save_ptr7", ddado0, 16'hB007);
        rst = 1;
        #1 verifica("rst_dump_valido", dval0, 0);
        verifica("rst_outA", outa0, 16'h0);
        ciclo();
        rst = 0;
        escreve = 1; selecaoin = 4'd0; reg_in = 16'h0077; salva = 1;
        ciclo();
        escreve = 0; salva = 0;
        verifica("reinicio_ptr0", ddado0, 16'h0077);
        dump_pronto = 1;
        n = 0;
        while (ocup0 && n < 100) begin ciclo(); n++; end
        verifica("reinicio_ciclos", n, NREG);
        dump_pronto = 0;

        // Randomized traffic
        repeat (1500) begin
            rst          = ($urandom_range(0, 299) == 0);
            salva        = ($urandom_range(0, 15) == 0);
            restaura     = ($urandom_range(0, 15) == 0);
            escreve      = $urandom_range(0, 1);
            selecaoin    = 4'($urandom);
            selecaooutA  = 4'($urandom);
            selecaooutB  = 4'($urandom);
            reg_in       = 16'($urandom);
            dump_pronto  = $urandom_range(0, 1);
            carga_valido = $urandom_range(0, 1);
            carga_dado   = 16'($urandom);
            ciclo();
        end

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end
endmodule
